bch_encode_serial: RTL and testbench
====================================

Name: bch_encode_serial

Overview:
- Serial systematic BCH encoder; the encode-side counterpart of the decoder chain (syndrome, key-equation solver, Chien search).
- Accepts K message bits one per transfer and passes them through unchanged while dividing by the generator polynomial in an LFSR.
- Then emits the P parity bits, so one N = K+P bit codeword leaves on a valid/ready stream.

Parameters:
M, 4, Galois field degree; N = 2^M-1 codeword bits
T, 3, correctable errors (documentation and assertion only; N must equal K+P)
K, 5, message bits per codeword
P, 10, parity bits = degree of generator polynomial
GEN, 11'h537, generator polynomial, P+1 bits, bit i = coefficient of x^i; bit P must be 1

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  1  message bit, first bit = highest-order message coefficient
in_valid  input  1  in_data is valid
in_ready  output  1  encoder accepts in_data this cycle
out_data  output  1  codeword bit, message bits then parity MSB-first
out_valid  output  1  out_data is valid
out_ready  input  1  sink accepts out_data this cycle
out_first  output  1  qualifies the codeword bit 0 beat (first message bit)
out_last  output  1  qualifies the final parity beat
busy  output  1  high from the first accepted message bit until the last parity beat transfers

Behaviour:
- Reset (async assert, sync release is the integrator's job): state = S_DATA, count = 0, lfsr = 0, busy = 0. in_ready and out_valid then follow S_DATA rules below.
- State register: S_DATA, S_PARITY. Counter width = clog2(max(K,P)).
- Transfer rules: an input transfer is in_valid && in_ready. An output transfer is out_valid && out_ready. Once out_valid is high, out_data, out_first and out_last stay stable until the output transfer.
- S_DATA (combinational pass-through, zero latency):
  - out_data = in_data, out_valid = in_valid, in_ready = out_ready.
  - out_first = (count == 0), out_last = 0.
- On each transfer in S_DATA:
  - fb = in_data ^ lfsr[P-1].
  - lfsr <= {lfsr[P-2:0],1'b0} ^ (fb ? GEN[P-1:0] : 0).
  - busy <= 1, count++.
  - On the K-th transfer: count <= 0, state <= S_PARITY.
- S_PARITY:
  - in_ready = 0, out_valid = 1, out_data = lfsr[P-1], out_first = 0, out_last = (count == P-1).
- On each output transfer in S_PARITY:
  - lfsr <= lfsr << 1, count++.
  - On the P-th transfer: count <= 0, state <= S_DATA, busy <= 0. lfsr is all zero by construction.
- Back-to-back codewords: the first message bit of the next codeword can transfer the cycle after the last parity beat. No idle cycle is inserted.
- Back-pressure: out_ready low stalls both phases with no state change. in_valid low in S_DATA stalls with no state change.
- in_data/in_valid are ignored in S_PARITY. The upstream source must hold its bit; it is not consumed.
- Reset asserted mid-codeword discards the partial codeword. There is no abort port.
- Elaboration check: GEN[P] == 1 and K+P == 2^M-1. Otherwise $error.

Test Plan:
- Message 00000 -> 15 output beats all 0. out_first on beat 0, out_last on beat 14, busy low afterwards.
- Message 00001 -> parity 0100110111. The full codeword equals GEN: 000010100110111.
- Message 10000 -> parity 1010011011. Message 10001 -> parity 1110101100 (linearity check).
- Message 11111 -> parity 1111111111 (all-ones codeword).
- Three back-to-back codewords (00001, 10000, 11111) with out_ready driven by an LFSR pseudo-random pattern and in_valid gaps:
  - Output bit stream identical to the no-stall case.
  - Exactly 45 output transfers.
  - in_ready never high in S_PARITY.
- rst_n pulsed low during parity beat 3 of message 10000, then message 00001 sent:
  - Outputs drop immediately: out_valid follows in_valid and busy = 0.
  - Following codeword 000010100110111 is correct with no residue.
- Scoreboard throughout: every codeword re-checked with a software polynomial division by GEN; remainder must be 0.

Source files
------------

// File: rtl/bch_encode_serial_if.sv
// Bit-serial message-in / codeword-out stream for the BCH encoder.
// master = message source and codeword sink side; slave = encoder side.
interface bch_encode_serial_if;
  logic in_data;
  logic in_valid;
  logic in_ready;
  logic out_data;
  logic out_valid;
  logic out_ready;
  logic out_first;
  logic out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last
  );
endinterface

// File: rtl/bch_encode_serial.sv
// Serial systematic BCH encoder: K message bits pass straight through (zero latency), then P parity bits.
// out_ready low stalls both phases; during parity the input is held off (in_ready low), not consumed.
module bch_encode_serial #(
  parameter int         M   = 4,
  parameter int         T   = 3,
  parameter int         K   = 5,
  parameter int         P   = 10,
  parameter logic [P:0] GEN = 11'h537
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bch_encode_serial_if.slave    bus,
  output logic                  busy
);

  localparam int MAXKP = (K > P) ? K : P;
  localparam int CW    = (MAXKP > 1) ? $clog2(MAXKP) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] P_LAST = CW'(P - 1);

  if (GEN[P] != 1'b1 || K + P != (1 << M) - 1 || P > M * T) begin : g_param_err
    $error("bch_encode_serial: GEN[P] must be 1, K+P must be 2^M-1, P must not exceed M*T");
  end

  typedef enum logic {S_DATA, S_PARITY} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [P-1:0]  lfsr;
  logic          fb;

  assign fb = bus.in_data ^ lfsr[P-1];

  // Data phase is a pure wire path; only the parity phase drives from state.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b1;
    bus.out_data  = lfsr[P-1];
    bus.out_first = 1'b0;
    bus.out_last  = (count == P_LAST);
    if (state == S_DATA) begin
      bus.in_ready  = bus.out_ready;
      bus.out_valid = bus.in_valid;
      bus.out_data  = bus.in_data;
      bus.out_first = (count == '0);
      bus.out_last  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_DATA;
      count <= '0;
      lfsr  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_DATA: begin
          if (bus.in_valid && bus.out_ready) begin
            lfsr <= {lfsr[P-2:0], 1'b0} ^ (fb ? GEN[P-1:0] : '0);
            busy <= 1'b1;
            if (count == K_LAST) begin
              count <= '0;
              state <= S_PARITY;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        S_PARITY: begin
          if (bus.out_ready) begin
            // Remainder drains MSB-first; register is empty after the last beat.
            lfsr <= {lfsr[P-2:0], 1'b0};
            if (count == P_LAST) begin
              count <= '0;
              state <= S_DATA;
              busy  <= 1'b0;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        default: begin
          state <= S_DATA;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_encode_serial.sv
// Randomized and directed bench for bch_encode_serial against a polynomial-division reference model.
module tb_bch_encode_serial;
  localparam int         K   = 5;
  localparam int         P   = 10;
  localparam int         N   = 15;
  localparam logic [P:0] GEN = 11'h537;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  bch_encode_serial_if bus();

  bch_encode_serial #(.M(4), .T(3), .K(K), .P(P), .GEN(GEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;
  int beats_total = 0;
  logic [7:0]   rlfsr = 8'hA5;
  logic [K-1:0] msgs[$];
  logic [N-1:0] exp_cw[$];
  logic [N-1:0] got_cw[$];
  logic [N-1:0] got_f[$];
  logic [N-1:0] got_l[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of a codeword polynomial divided by GEN (long division over GF(2)).
  function automatic logic [P-1:0] poly_rem(input logic [N-1:0] cw);
    logic [N-1:0] r;
    logic [N-1:0] g;
    r = cw;
    g = N'(GEN);
    for (int i = N - 1; i >= P; i--)
      if (r[i]) r = r ^ (g << (i - P));
    return r[P-1:0];
  endfunction

  function automatic logic [N-1:0] encode_ref(input logic [K-1:0] msg);
    logic [N-1:0] shifted;
    shifted = {msg, {P{1'b0}}};
    return shifted | N'(poly_rem(shifted));
  endfunction

  task automatic run_stream(input bit stall, input bit gaps, input int stop_at, input int drain);
    int nmsg, src_msg, src_bit, beats, idle, cyc, limit;
    bit consumed, hold;
    logic [2:0]   prev;
    logic [N-1:0] cw, fv, lv;
    nmsg = msgs.size();
    src_msg = 0; src_bit = 0; beats = 0; idle = 0; cyc = 0;
    consumed = 0; hold = 0; prev = '0; cw = '0; fv = '0; lv = '0;
    limit = (stop_at > 0) ? stop_at : nmsg * N;
    while ((beats < limit || idle < drain) && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (beats >= limit) idle++;
      if (consumed) begin
        bus.in_valid = 1'b0;
        consumed = 0;
      end
      if (!bus.in_valid && src_msg < nmsg && (!gaps || $urandom_range(0, 3) != 0)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = msgs[src_msg][K-1-src_bit];
      end
      rlfsr = {rlfsr[6:0], rlfsr[7] ^ rlfsr[5] ^ rlfsr[4] ^ rlfsr[3]};
      bus.out_ready = stall ? rlfsr[0] : 1'b1;
      @(negedge clk);
      if (hold) check("stable", {29'd0, bus.out_data, bus.out_first, bus.out_last}, {29'd0, prev});
      if (beats % N >= K) check("in_ready_parity", {31'd0, bus.in_ready}, 0);
      check("busy", {31'd0, busy}, {31'd0, (beats % N) != 0});
      if (bus.in_valid && bus.in_ready) begin
        consumed = 1;
        src_bit++;
        if (src_bit == K) begin
          src_bit = 0;
          src_msg++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        cw = {cw[N-2:0], bus.out_data};
        fv = {fv[N-2:0], bus.out_first};
        lv = {lv[N-2:0], bus.out_last};
        beats++;
        if (beats % N == 0) begin
          got_cw.push_back(cw);
          got_f.push_back(fv);
          got_l.push_back(lv);
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      prev = {bus.out_data, bus.out_first, bus.out_last};
    end
    beats_total = beats;
    if (beats < limit) check("timeout", beats, limit);
  endtask

  task automatic verify_cws();
    check("cw_count", got_cw.size(), exp_cw.size());
    for (int i = 0; i < got_cw.size() && i < exp_cw.size(); i++) begin
      check($sformatf("codeword%0d", i), {17'd0, got_cw[i]}, {17'd0, exp_cw[i]});
      check($sformatf("first%0d", i), {17'd0, got_f[i]}, 32'h4000);
      check($sformatf("last%0d", i), {17'd0, got_l[i]}, 32'h0001);
      check($sformatf("remainder%0d", i), {22'd0, poly_rem(got_cw[i])}, 0);
    end
    got_cw.delete(); got_f.delete(); got_l.delete(); exp_cw.delete(); msgs.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_in_ready_lo", {31'd0, bus.in_ready}, 0);
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready_hi", {31'd0, bus.in_ready}, 1);
    check("rst_out_first", {31'd0, bus.out_first}, 1);
    check("rst_out_last", {31'd0, bus.out_last}, 0);
    rst_n = 1'b1;

    // Known-answer codewords, back to back without stalls.
    msgs = '{5'b00000, 5'b00001, 5'b10000, 5'b10001, 5'b11111};
    exp_cw = '{15'h0000, 15'b000010100110111, 15'b100001010011011,
               15'b100011110101100, 15'h7FFF};
    run_stream(0, 0, 0, 3);
    verify_cws();

    // Same stream content under random back-pressure and source gaps.
    msgs = '{5'b00001, 5'b10000, 5'b11111};
    exp_cw = '{15'b000010100110111, 15'b100001010011011, 15'h7FFF};
    run_stream(1, 1, 0, 6);
    check("xfers", beats_total, 45);
    verify_cws();

    for (int i = 0; i < 8; i++) begin
      logic [K-1:0] m;
      m = K'($urandom_range(0, 31));
      msgs.push_back(m);
      exp_cw.push_back(encode_ref(m));
    end
    run_stream(1, 1, 0, 4);
    verify_cws();

    // Reset during parity beat 3 of message 10000.
    msgs = '{5'b10000};
    run_stream(0, 0, 8, 0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, bus.out_valid}, 1);
    check("pre_rst_parity3", {31'd0, bus.out_data}, 0);
    check("pre_rst_busy", {31'd0, busy}, 1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_lo", {31'd0, bus.out_valid}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 1'b1;
    #1;
    check("mid_rst_valid_hi", {31'd0, bus.out_valid}, 1);
    check("mid_rst_data", {31'd0, bus.out_data}, 1);
    check("mid_rst_first", {31'd0, bus.out_first}, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got_cw.delete(); got_f.delete(); got_l.delete(); msgs.delete();
    msgs = '{5'b00001};
    exp_cw = '{15'b000010100110111};
    run_stream(0, 0, 0, 3);
    verify_cws();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
